fwrisc_mem_arbiter: RTL
=======================

Name: fwrisc_mem_arbiter

Overview:
- Shares one memory port between the core's instruction-fetch port and data port, so fwrisc can run from a single unified memory.
- Sits between fwrisc and the memory/bus bridge.
- Arbitrates round-robin, holds the grant until the memory responds, and registers the winner's request.
- A watchdog ends any stalled transfer with an error flag.

Parameters:
- TIMEOUT_CYCLES, 256, cycles a granted transfer may wait for mready before forced completion; 0 disables the watchdog.
- ERR_RDATA, 32'h0000_0000, read data returned on a timed-out transfer.

Ports:
- clock  in  1  single clock; all logic on posedge
- reset  in  1  asynchronous, active-low reset (reset==0 resets)
- iaddr  in  32  fetch address
- ivalid  in  1  fetch request
- idata  out  32  fetch read data
- iready  out  1  fetch completion strobe
- ierr  out  1  fetch timed out (valid with iready)
- daddr  in  32  data address
- dwdata  in  32  store data
- dstrb  in  4  byte strobes
- dwrite  in  1  1=store, 0=load
- dvalid  in  1  data request
- drdata  out  32  load data
- dready  out  1  data completion strobe
- derr  out  1  data access timed out (valid with dready)
- maddr  out  32  memory address
- mwdata  out  32  memory write data
- mstrb  out  4  memory strobes
- mwrite  out  1  memory write enable
- mvalid  out  1  memory request
- mrdata  in  32  memory read data
- mready  in  1  memory completion

Behaviour:
- Requester protocol:
  - A requester holds valid and its fields stable until its ready.
  - It deasserts valid in the cycle after ready unless it issues a new request.
- States: IDLE, BUSY_I, BUSY_D.
- Reset (reset==0, asynchronous):
  - state=IDLE, last_grant=D, timeout count=0.
  - maddr/mwdata/mstrb/mwrite/mvalid=0.
  - iready/dready/ierr/derr=0.
  - Outputs drop immediately, not at the next edge.
- IDLE:
  - Only ivalid: grant I.
  - Only dvalid: grant D.
  - Both: grant the requester not equal to last_grant; the first tie after reset goes to I.
  - On grant: register the winner's address/wdata/strb/write into maddr/mwdata/mstrb/mwrite.
  - I grant forces mwrite=0, mstrb=4'hF, mwdata=0.
  - Update last_grant, go to BUSY_x, clear timeout count.
- BUSY_x:
  - mvalid=1. maddr/mwdata/mstrb/mwrite held constant.
  - When mvalid&&mready: assert x_ready=1 combinationally in that cycle, x_rdata=mrdata, x_err=0; next state IDLE.
- Latency:
  - Request seen in cycle N (IDLE) → mvalid in N+1.
  - A zero-wait memory completes in N+1.
  - Back-to-back requests have a 2-cycle minimum per transfer; IDLE always separates transfers.
- Non-granted requester: ready=0, err=0, rdata=0. Its request is served in a later IDLE; it is never dropped.
- Watchdog (TIMEOUT_CYCLES>0):
  - 16-bit counter increments each BUSY cycle with mready=0.
  - When count==TIMEOUT_CYCLES-1 and mready=0: assert x_ready=1, x_err=1, x_rdata=ERR_RDATA; go to IDLE; mvalid drops next cycle.
  - mready in that same cycle takes precedence: normal completion, err=0.
- Requester deasserting valid mid-transfer (protocol violation): the transfer still completes on the memory side and x_ready still pulses. No abort.
- mready while in IDLE is ignored.
- Outputs idata/drdata are 0 when the corresponding ready=0.
- Fairness: with both valids continuously asserted, grants alternate I,D,I,D.

Decomposition:
- Package fwrisc_mem_arb_pkg: state enum arb_state_e {IDLE, BUSY_I, BUSY_D}; grant enum grant_e {GRANT_I, GRANT_D}; constant TIMEOUT_W=16.
- Sub-module fwrisc_rr_arb2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_grant.
  - Outputs: gnt[1:0] (one-hot or zero).
  - Used by IDLE.
- The FSM, request registers, and watchdog stay in fwrisc_mem_arbiter.

Test Plan:
- Single fetch: ivalid=1, iaddr=0x0000_0100, mready tied 1, mrdata=0x0010_0093 → mvalid in cycle 1 with maddr=0x100, mwrite=0; iready=1 and idata=0x0010_0093 in cycle 1; ierr=0; state IDLE in cycle 2.
- Store: dvalid=1, dwrite=1, daddr=0x0000_2004, dwdata=0xCAFE_F00D, dstrb=4'b0011, mready after 3 wait cycles → mwrite=1, mwdata=0xCAFE_F00D, mstrb=4'b0011 stable all 4 BUSY cycles; dready pulses once; derr=0.
- Contention: ivalid and dvalid both held high for 8 transfers with a zero-wait memory → grant order I,D,I,D,I,D,I,D; each requester sees exactly 4 ready pulses.
- Timeout: TIMEOUT_CYCLES=4, dvalid load at 0x3000, mready=0 forever → dready=1, derr=1, drdata=ERR_RDATA in the 4th BUSY cycle; mvalid=0 the next cycle.
- Timeout/ready race: TIMEOUT_CYCLES=4, mready=1 exactly in the 4th BUSY cycle with mrdata=0x1234_5678 → dready=1, derr=0, drdata=0x1234_5678.
- Async reset mid-transfer: assert reset=0 between clock edges while in BUSY_D → mvalid and dready drop to 0 before the next edge. After release, a pending ivalid and dvalid tie → I is granted first.

Source files
------------

// File: rtl/fwrisc_mem_arb_pkg.sv
// fwrisc_mem_arb_pkg
//   Shared types for the fwrisc fetch/data memory arbiter.
//   arb_state_e : arbiter FSM state (IDLE, BUSY_I, BUSY_D)
//   grant_e     : which requester was granted last (round-robin history)
//   TIMEOUT_W   : width of the watchdog cycle counter
package fwrisc_mem_arb_pkg;

  localparam int TIMEOUT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

endpackage

// File: rtl/fwrisc_rr_arb2.sv
// fwrisc_rr_arb2
//   Combinational 2-way round-robin picker.
//   req[0] = instruction fetch, req[1] = data access.
//   last_grant : requester that won the previous arbitration
//   gnt[1:0]   : one-hot grant, or zero when nothing is requested
//   On a tie the requester that did not win last time is chosen.
module fwrisc_rr_arb2
  import fwrisc_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  grant_e     last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == GRANT_I) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/fwrisc_mem_arbiter.sv
// fwrisc_mem_arbiter
//   Shares one memory port between the fwrisc fetch port (i*) and data
//   port (d*). Round-robin arbitration in IDLE, the winner's request is
//   registered onto the memory port and held until mready (or until the
//   watchdog forces completion with an error flag).
//
//   Ports
//     clock, reset         : clock, asynchronous active-low reset
//     iaddr/ivalid         : fetch request        idata/iready/ierr : response
//     daddr/dwdata/dstrb/
//     dwrite/dvalid        : data request         drdata/dready/derr: response
//     maddr/mwdata/mstrb/
//     mwrite/mvalid        : memory request       mrdata/mready     : response
//     dbg_state            : current FSM state (observation only)
//
//   Handshake: a requester raises valid with stable fields and keeps them
//   until its ready pulses for one cycle; ready/rdata/err are valid only in
//   that cycle. On the memory side mvalid stays high with stable fields
//   until the cycle in which mready is sampled high; mready outside a
//   transfer is ignored. One IDLE cycle always separates two transfers.
module fwrisc_mem_arbiter
  import fwrisc_mem_arb_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] iaddr,
  input  logic        ivalid,
  output logic [31:0] idata,
  output logic        iready,
  output logic        ierr,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dstrb,
  input  logic        dwrite,
  input  logic        dvalid,
  output logic [31:0] drdata,
  output logic        dready,
  output logic        derr,
  output logic [31:0] maddr,
  output logic [31:0] mwdata,
  output logic [3:0]  mstrb,
  output logic        mwrite,
  output logic        mvalid,
  input  logic [31:0] mrdata,
  input  logic        mready,
  output arb_state_e  dbg_state
);

  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TIMEOUT_W-1:0] TO_LAST =
    WD_EN ? TIMEOUT_W'(TIMEOUT_CYCLES - 1) : '0;

  arb_state_e           state, state_nxt;
  grant_e               last_grant;
  logic [1:0]           gnt;
  logic [TIMEOUT_W-1:0] to_cnt;
  logic                 timeout;

  fwrisc_rr_arb2 u_rr (
    .req        ({dvalid, ivalid}),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and responses. Responses are combinational so a zero-wait
  // memory completes in the first BUSY cycle.
  always_comb begin
    state_nxt = state;
    mvalid    = 1'b0;
    timeout   = 1'b0;
    iready    = 1'b0;
    ierr      = 1'b0;
    idata     = 32'h0;
    dready    = 1'b0;
    derr      = 1'b0;
    drdata    = 32'h0;
    case (state)
      IDLE: begin
        if (gnt[0])      state_nxt = BUSY_I;
        else if (gnt[1]) state_nxt = BUSY_D;
      end
      BUSY_I, BUSY_D: begin
        mvalid = 1'b1;
        // A real mready in the last watchdog cycle wins over the timeout.
        timeout = WD_EN && !mready && (to_cnt == TO_LAST);
        if (mready || timeout) begin
          state_nxt = IDLE;
          if (state == BUSY_I) begin
            iready = 1'b1;
            ierr   = timeout;
            idata  = timeout ? ERR_RDATA : mrdata;
          end else begin
            dready = 1'b1;
            derr   = timeout;
            drdata = timeout ? ERR_RDATA : mrdata;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request registers and round-robin history; loaded only on a grant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      maddr      <= 32'h0;
      mwdata     <= 32'h0;
      mstrb      <= 4'h0;
      mwrite     <= 1'b0;
      last_grant <= GRANT_D;
    end else if (state == IDLE) begin
      if (gnt[0]) begin
        maddr      <= iaddr;
        mwdata     <= 32'h0;
        mstrb      <= 4'hF;
        mwrite     <= 1'b0;
        last_grant <= GRANT_I;
      end else if (gnt[1]) begin
        maddr      <= daddr;
        mwdata     <= dwdata;
        mstrb      <= dstrb;
        mwrite     <= dwrite;
        last_grant <= GRANT_D;
      end
    end
  end

  // Watchdog: counts BUSY cycles without mready; zeroed while IDLE so each
  // transfer starts from 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                   to_cnt <= '0;
    else if (state == IDLE)       to_cnt <= '0;
    else if (!mready)             to_cnt <= to_cnt + 1'b1;
  end

  assign dbg_state = state;

endmodule
